// File: rtl/pipe_stage_pkg.sv
// rtl/pipe_stage_pkg.sv - shared types for the pipe_stage register slice
package pipe_stage_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_CNT_W  = 16;

    // Next-cycle action applied to the main (output) entry.
    typedef enum logic [1:0] {
        ACT_HOLD      = 2'd0,
        ACT_LOAD_IN   = 2'd1,
        ACT_LOAD_SKID = 2'd2,
        ACT_CLEAR     = 2'd3
    } main_act_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - single overflow entry (payload + valid) used by pipe_stage
module pipe_skid_buf #(
    parameter int                 DATA_W = 64,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear_i) begin
            valid_d = 1'b0;
            data_d  = BUBBLE;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - pipeline stage register with flush and stall counter; PIPE_SKID_EN adds a skid entry
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int                 DATA_W = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
    parameter int                 CNT_W  = DEFAULT_CNT_W
) (
    input  logic              psi_clk,
    input  logic              psi_rst,
    input  logic              psi_valid,
    input  logic [DATA_W-1:0] psi_data,
    output logic              pso_ready,
    input  logic              psi_flush,
    output logic              pso_valid,
    output logic [DATA_W-1:0] pso_data,
    input  logic              psi_ready,
    output logic [CNT_W-1:0]  pso_stall_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              xfer_in, xfer_out;
    logic [DATA_W-1:0] skid_data;
    main_act_e         act;

    assign xfer_out = valid_q & psi_ready;

`ifdef PIPE_SKID_EN
    logic skid_valid, skid_load, skid_clear;

    // Ready is registered: only the skid entry's occupancy gates intake.
    assign pso_ready = ~skid_valid;
    assign xfer_in   = psi_valid & ~skid_valid;

    always_comb begin
        act        = ACT_HOLD;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (psi_flush) begin
            act        = ACT_CLEAR;
            skid_clear = 1'b1;
        end else if (xfer_out) begin
            if (skid_valid) begin
                act        = ACT_LOAD_SKID;
                skid_clear = 1'b1;
            end else if (xfer_in) begin
                act = ACT_LOAD_IN;
            end else begin
                act = ACT_CLEAR;
            end
        end else if (xfer_in) begin
            if (valid_q) begin
                skid_load = 1'b1;
            end else begin
                act = ACT_LOAD_IN;
            end
        end
    end

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk_i   (psi_clk),
        .rst_i   (psi_rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .data_i  (psi_data),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );
`else
    assign pso_ready = psi_ready | ~valid_q;
    assign xfer_in   = psi_valid & pso_ready;
    assign skid_data = BUBBLE;

    always_comb begin
        act = ACT_HOLD;
        if (psi_flush) begin
            act = ACT_CLEAR;
        end else if (xfer_in) begin
            act = ACT_LOAD_IN;
        end else if (xfer_out) begin
            act = ACT_CLEAR;
        end
    end
`endif

    // An empty main entry always holds BUBBLE so pso_data needs no output mux.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        case (act)
            ACT_LOAD_IN: begin
                valid_d = 1'b1;
                data_d  = psi_data;
            end
            ACT_LOAD_SKID: begin
                valid_d = 1'b1;
                data_d  = skid_data;
            end
            ACT_CLEAR: begin
                valid_d = 1'b0;
                data_d  = BUBBLE;
            end
            default: begin
                valid_d = valid_q;
                data_d  = data_q;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !psi_ready && !(&cnt_q)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge psi_clk or posedge psi_rst) begin
        if (psi_rst) begin
            valid_q <= 1'b0;
            data_q  <= BUBBLE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pso_valid     = valid_q;
    assign pso_data      = data_q;
    assign pso_stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - directed self-checking bench for pipe_stage
module tb_pipe_stage;

    localparam int          DATA_W = 64;
    localparam int          CNT_W  = 4;
    localparam logic [63:0] BUB    = 64'h00F0_0000_0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_ready_in;
    logic              flush = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              ds_ready = 1'b1;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage #(
        .DATA_W (DATA_W),
        .BUBBLE (BUB),
        .CNT_W  (CNT_W)
    ) dut (
        .psi_clk       (clk),
        .psi_rst       (rst),
        .psi_valid     (in_valid),
        .psi_data      (in_data),
        .pso_ready     (out_ready_in),
        .psi_flush     (flush),
        .pso_valid     (out_valid),
        .pso_data      (out_data),
        .psi_ready     (ds_ready),
        .pso_stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        ds_ready = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== BUB) begin errors++; $display("FAIL reset_data got=%h exp=%h", out_data, BUB); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (out_ready_in !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", out_ready_in); end
        // load 9 under back-pressure, then reset asynchronously mid-cycle
        ds_ready = 1'b0; in_valid = 1'b1; in_data = 64'd9;
        tick();
        in_valid = 1'b0;
        tick();
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL pre_reset_cnt got=%0d exp=1", stall_cnt); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== BUB) begin errors++; $display("FAIL async_reset_data got=%h exp=%h", out_data, BUB); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL async_reset_cnt got=%0d exp=0", stall_cnt); end
        rst = 1'b0; ds_ready = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        do_reset();
        ds_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 64'(i);
            tick();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
            checks++; if (out_data !== 64'(i)) begin errors++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, 64'(i)); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== BUB) begin errors++; $display("FAIL stream_drain_data got=%h exp=%h", out_data, BUB); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ds_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5;
        tick();
        in_data = 64'd6;
        for (int i = 0; i < 3; i++) begin
            tick();
`ifdef PIPE_SKID_EN
            in_valid = 1'b0;
`endif
            checks++; if (out_data !== 64'd5) begin errors++; $display("FAIL bp_hold_data[%0d] got=%h exp=5", i, out_data); end
            checks++; if (out_ready_in !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0", i, out_ready_in); end
        end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL bp_cnt got=%0d exp=3", stall_cnt); end
        in_valid = 1'b0; ds_ready = 1'b1;
        tick();
`ifdef PIPE_SKID_EN
        checks++; if (out_data !== 64'd6 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_skid_out got=%h/%b exp=6/1", out_data, out_valid); end
        tick();
`endif
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== BUB) begin errors++; $display("FAIL bp_release_data got=%h exp=%h", out_data, BUB); end
        checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL bp_cnt_hold got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        ds_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5;
        tick();
`ifdef PIPE_SKID_EN
        in_data = 64'd6;
        tick();
`endif
        flush = 1'b1; ds_ready = 1'b1; in_valid = 1'b1; in_data = 64'd7;
        #1;
`ifdef PIPE_SKID_EN
        checks++; if (out_ready_in !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", out_ready_in); end
`else
        checks++; if (out_ready_in !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", out_ready_in); end
`endif
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== BUB) begin errors++; $display("FAIL flush_data got=%h exp=%h", out_data, BUB); end
        flush = 1'b0; in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_data === 64'd7) begin errors++; $display("FAIL flush_after got=%h/%b exp=bubble/0", out_data, out_valid); end
        checks++; if (out_ready_in !== 1'b1) begin errors++; $display("FAIL flush_after_ready got=%b exp=1", out_ready_in); end
    endtask

    task automatic test_saturation();
        do_reset();
        ds_ready = 1'b0; in_valid = 1'b1; in_data = 64'd8;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_mid got=%0d exp=14", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_top got=%0d exp=15", stall_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_flush got=%0d exp=15", stall_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_flush_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_bubble();
        do_reset();
        ds_ready = 1'b1; in_valid = 1'b0; in_data = 64'hDEAD_DEAD_DEAD_DEAD;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== BUB) begin errors++; $display("FAIL bubble_data got=%h exp=%h", out_data, BUB); end
        tick();
        checks++; if (out_data !== BUB) begin errors++; $display("FAIL bubble_data2 got=%h exp=%h", out_data, BUB); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_flush();
        test_saturation();
        test_bubble();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
